// File: rtl/bus_arbiter.sv
// bus_arbiter: registered 4-class priority arbiter (aged L1 > L1 evict RR > page walker RR > L1 read RR); in CLK, RST, l1_req, l1_evict, pw_req, txn_done; out grant_valid/id/onehot/pw/evict, starve
module bus_arbiter #(
  parameter int NUM_L1 = 4,
  parameter int NUM_PW = 2,
  parameter int AGE_LIMIT = 15,
  localparam int ID_W = NUM_L1 + NUM_PW > 2 ? $clog2(NUM_L1 + NUM_PW) : 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic [NUM_L1-1:0] l1_req,
  input  logic [NUM_L1-1:0] l1_evict,
  input  logic [NUM_PW-1:0] pw_req,
  input  logic txn_done,
  output logic grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic [NUM_L1+NUM_PW-1:0] grant_onehot,
  output logic grant_pw,
  output logic grant_evict,
  output logic starve
);
  localparam int NT = NUM_L1 + NUM_PW;
  localparam int LW = NUM_L1 > 1 ? $clog2(NUM_L1) : 1;
  localparam int PWW = NUM_PW > 1 ? $clog2(NUM_PW) : 1;
  localparam int AW = $clog2(AGE_LIMIT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic grant_valid_q, grant_valid_d, grant_pw_q, grant_pw_d, grant_evict_q, grant_evict_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [NT-1:0] grant_onehot_q, grant_onehot_d;
  logic [LW-1:0] l1_ptr_q, l1_ptr_d;
  logic [PWW-1:0] pw_ptr_q, pw_ptr_d;
  logic [AW-1:0] age_q [NUM_L1];
  logic [AW-1:0] age_d [NUM_L1];
  logic [NUM_L1-1:0] sat, aged;
  logic [15:0] ev16;
  logic [4:0] sel_a, sel_b, sel_c, sel_d, win_id, win_nxt;
  logic [3:0] win_idx;
  logic take_a, take_b, take_c, req_any, win_ev, load;
  function automatic logic [4:0] rr(input logic [31:0] m, input int ptr, input int n);
    logic [4:0] r;
    int j;
    r = '0;
    for (int k = 15; k >= 0; k--) begin
      j = ptr + k >= n ? ptr + k - n : ptr + k;
      if (k < n && m[j]) r = {1'b1, 4'(j)};
    end
    return r;
  endfunction
  always_comb begin
    sat = '0;
    for (int i = 0; i < NUM_L1; i++) sat[i] = age_q[i] == AW'(AGE_LIMIT);
  end
  assign aged = sat & l1_req;
  assign starve = |sat;
  assign ev16 = 16'(l1_evict);
  assign sel_a = rr(32'(aged), 0, NUM_L1);
  assign sel_b = rr(32'(l1_req & l1_evict), int'(l1_ptr_q), NUM_L1);
  assign sel_c = rr(32'(pw_req), int'(pw_ptr_q), NUM_PW);
  assign sel_d = rr(32'(l1_req & ~l1_evict), int'(l1_ptr_q), NUM_L1);
  assign take_a = sel_a[4];
  assign take_b = !take_a && sel_b[4];
  assign take_c = !take_a && !sel_b[4] && sel_c[4];
  assign req_any = sel_a[4] | sel_b[4] | sel_c[4] | sel_d[4];
  assign win_idx = take_a ? sel_a[3:0] : take_b ? sel_b[3:0] : take_c ? sel_c[3:0] : sel_d[3:0];
  assign win_id = take_c ? 5'(win_idx) + 5'(NUM_L1) : 5'(win_idx);
  assign win_nxt = 5'(win_idx) + 5'd1;
  assign win_ev = !take_c && ev16[win_idx];
  assign load = state_q == IDLE && req_any;
  always_comb begin
    state_d = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d = grant_id_q;
    grant_onehot_d = grant_onehot_q;
    grant_pw_d = grant_pw_q;
    grant_evict_d = grant_evict_q;
    l1_ptr_d = l1_ptr_q;
    pw_ptr_d = pw_ptr_q;
    if (load) begin
      state_d = BUSY;
      grant_valid_d = 1'b1;
      grant_id_d = ID_W'(win_id);
      grant_onehot_d = NT'(1) << win_id;
      grant_pw_d = take_c;
      grant_evict_d = win_ev;
      if (take_c) pw_ptr_d = win_nxt == 5'(NUM_PW) ? '0 : PWW'(win_nxt);
      else l1_ptr_d = win_nxt == 5'(NUM_L1) ? '0 : LW'(win_nxt);
    end else if (state_q == BUSY && txn_done) begin
      state_d = IDLE;
      grant_valid_d = 1'b0;
      grant_id_d = '0;
      grant_onehot_d = '0;
      grant_pw_d = 1'b0;
      grant_evict_d = 1'b0;
    end
    for (int i = 0; i < NUM_L1; i++)
      age_d[i] = (!l1_req[i] || (load && !take_c && win_idx == 4'(i)) ||
                  (grant_valid_q && !grant_pw_q && grant_id_q == ID_W'(i))) ? '0 :
                 sat[i] ? age_q[i] : age_q[i] + AW'(1);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q <= '0;
      grant_onehot_q <= '0;
      grant_pw_q <= 1'b0;
      grant_evict_q <= 1'b0;
      l1_ptr_q <= '0;
      pw_ptr_q <= '0;
      for (int i = 0; i < NUM_L1; i++) age_q[i] <= '0;
    end else begin
      state_q <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q <= grant_id_d;
      grant_onehot_q <= grant_onehot_d;
      grant_pw_q <= grant_pw_d;
      grant_evict_q <= grant_evict_d;
      l1_ptr_q <= l1_ptr_d;
      pw_ptr_q <= pw_ptr_d;
      age_q <= age_d;
    end
  end
  assign grant_valid = grant_valid_q;
  assign grant_id = grant_id_q;
  assign grant_onehot = grant_onehot_q;
  assign grant_pw = grant_pw_q;
  assign grant_evict = grant_evict_q;
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_L1, default 4 (NUM_HARTS*2), number of L1 requesters; legal range 1-16.
REQ-002 Parameter NUM_PW, default 2 (NUM_HARTS), number of page-walker requesters; legal range 1-8.
REQ-003 Parameter AGE_LIMIT, default 15, count of waiting cycles before an L1 requester is promoted; legal range 1-255.
REQ-004 Derived localparam ID_W = max(1, $clog2(NUM_L1+NUM_PW)).
REQ-005 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 RST  input  1  synchronous reset, active-high.
REQ-007 l1_req  input  NUM_L1  per-L1 read/readX request, level, held until granted.
REQ-008 l1_evict  input  NUM_L1  qualifies l1_req[i] as writeback/eviction; ignored when l1_req[i]=0.
REQ-009 pw_req  input  NUM_PW  per-page-walker read request, level, held until granted.
REQ-010 txn_done  input  1  pulse from coherence FSM marking end of current granted transaction.
REQ-011 grant_valid  output  1  a grant is active.
REQ-012 grant_id  output  ID_W  winner: L1 i -> i, page walker j -> NUM_L1+j.
REQ-013 grant_onehot  output  NUM_L1+NUM_PW  one-hot form of grant_id; all-zero when grant_valid=0.
REQ-014 grant_pw  output  1  winner is a page walker.
REQ-015 grant_evict  output  1  winner is an L1 eviction.
REQ-016 starve  output  1  some L1 age counter equals AGE_LIMIT.

Function
REQ-017 FSM has two states, IDLE and BUSY; all grant outputs are registered.
REQ-018 IDLE: if any request is present, the winner is selected combinationally and, on the next edge, the grant outputs load and the FSM moves to BUSY; otherwise it remains in IDLE with grant_valid=0.
REQ-019 Grant latency is exactly 1 cycle: request sampled in IDLE at edge t produces grant_valid=1 after edge t.
REQ-020 BUSY: grant outputs hold constant regardless of request changes until txn_done=1; on that edge the FSM returns to IDLE and grant_valid clears.
REQ-021 Back-to-back grants have one IDLE bubble cycle between them; txn_done while in IDLE is ignored.
REQ-022 Priority, highest first: (a) aged L1 requester (age==AGE_LIMIT), lowest index wins; (b) L1 evictions, round-robin; (c) page walkers, round-robin; (d) L1 non-evict requests, round-robin.
REQ-023 Separate round-robin pointers exist for classes b, c and d; search starts at the pointer and wraps modulo the class size.
REQ-024 On a grant in class b or d, both L1 pointers become (i+1) mod NUM_L1; on a grant in class c, the PW pointer becomes (j+1) mod NUM_PW; a class (a) grant updates the L1 pointers the same way.
REQ-025 Per-L1 age counter, width $clog2(AGE_LIMIT+1): increments each cycle l1_req[i]=1 and i is not the registered winner, saturates at AGE_LIMIT, and clears when l1_req[i]=0 or when i is granted.
REQ-026 Age counters also advance during BUSY, so a long transaction can promote waiting requesters.
REQ-027 With NUM_L1=1 or NUM_PW=1, the pointer for that class is constant 0.
REQ-028 A request dropped before its grant is not granted and causes no error; the arbiter does not check request stability.

Reset
REQ-029 While RST=1 at an edge: FSM -> IDLE, grant_valid=0, grant_id=0, grant_onehot=0, grant_pw=0, grant_evict=0, all pointers=0, all age counters=0, starve=0.
REQ-030 RST asserted during BUSY abandons the grant with no txn_done needed; the first arbitration after release occurs in the cycle following deassertion.

Verification
REQ-031 Defaults; l1_req=4'b0101, and txn_done 3 cycles after each grant -> grants in order id 0, 2, 0, 2, with one bubble between grants.
REQ-032 l1_req=4'b0011, l1_evict=4'b0010, pw_req=2'b01 together from IDLE -> first grant id 1 with grant_evict=1, then id 4 with grant_pw=1, then id 0.
REQ-033 pw_req=2'b11 held continuously, l1_req[3]=1 held, each transaction 1 cycle -> L1 3 is granted once its age reaches 15, and starve=1 in the cycle before that grant.
REQ-034 Grant active (id 2); l1_req toggles and pw_req rises with no txn_done for 10 cycles -> grant_id, grant_onehot=6'b000100 and grant_valid remain stable throughout.
REQ-035 RST=1 for 1 cycle mid-BUSY with requests pending -> next cycle all outputs are 0; grant re-issues from pointer 0 one cycle after RST falls.
REQ-036 NUM_L1=1, NUM_PW=1, both requesting, 1-cycle transactions -> the PW is always granted until the L1 age reaches AGE_LIMIT, then the L1 is granted.
